// File: rtl/instr_fetch_if.sv
// Instruction-memory read port: single-word request with a data-bearing ack.
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: IDLE -> FETCH -> EXEC loop with branch/jump next-PC.
// Optional fetch timeout to a sticky ERROR state under macro FETCH_TIMEOUT_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h00000000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_if.master      imem,
    input  logic               Branch,
    input  logic               Zero,
    input  logic               Jump,
    // Branch offset field; "const" itself is a reserved word.
    input  logic [15:0]        br_const,
    input  logic [25:0]        address,
    input  logic               stall,
    output logic [31:0]        InstrReg,
    output logic [31:0]        PC,
    output logic               instr_valid,
    output logic               fetch_err
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, ERROR} state_t;

    state_t      state, state_n;
    logic [31:0] pc4, next_pc;
    logic        to_hit;

    always_comb begin
        pc4     = PC + 32'd4;
        next_pc = pc4;
        if (Jump)
            next_pc = {pc4[31:28], address, 2'b00};
        else if (Branch && Zero)
            next_pc = pc4 + {{14{br_const[15]}}, br_const, 2'b00};
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tcnt;

    // Counter is held at zero outside FETCH, so every FETCH entry starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tcnt <= '0;
        else if (state != FETCH)
            tcnt <= '0;
        else if (!imem.imem_ack)
            tcnt <= tcnt + 1'b1;
    end

    assign to_hit = (tcnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fetch_err <= 1'b0;
        else if (state == FETCH && !imem.imem_ack && to_hit)
            fetch_err <= 1'b1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign to_hit         = 1'b0;
    assign fetch_err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = FETCH;
            FETCH:   if (imem.imem_ack)  state_n = EXEC;
                     else if (to_hit)    state_n = ERROR;
            EXEC:    if (!stall)         state_n = FETCH;
            default: state_n = state;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC          <= RESET_PC;
            InstrReg    <= 32'h0;
            instr_valid <= 1'b0;
        end else begin
            if (state == FETCH && imem.imem_ack) begin
                InstrReg    <= imem.imem_rdata;
                instr_valid <= 1'b1;
            end
            if (state == EXEC && !stall) begin
                PC          <= next_pc;
                instr_valid <= 1'b0;
            end
        end
    end

    assign imem.imem_req  = (state == FETCH);
    assign imem.imem_addr = PC;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against a transaction-level reference model.
module tb_instr_fetch;
    localparam logic [31:0] RESET_PC = 32'h00000000;
    localparam int          TO       = 16;
`ifdef FETCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Branch, Zero, Jump, stall;
    logic [15:0] br_const;
    logic [25:0] address;
    logic [31:0] InstrReg, PC;
    logic        instr_valid, fetch_err;

    always #5 clk = ~clk;

    instr_fetch_if bus();

    instr_fetch #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .imem(bus.master),
        .Branch(Branch), .Zero(Zero), .Jump(Jump), .br_const(br_const),
        .address(address), .stall(stall), .InstrReg(InstrReg), .PC(PC),
        .instr_valid(instr_valid), .fetch_err(fetch_err)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: mode 0 idle, 1 fetching, 2 executing, 3 error
    int          m_mode, m_wait;
    logic [31:0] m_pc, m_instr;
    logic        m_err;

    // Controls for the instruction currently being run
    logic        d_br, d_z, d_j, d_st;
    logic [15:0] d_c;
    logic [25:0] d_a;
    logic [31:0] d_data;
    int          d_lat;

    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic br, z, j,
                                             input logic [15:0] c, input logic [25:0] a);
        logic [31:0] pc4 = pc + 32'd4;
        if (j)       return (pc4 & 32'hF000_0000) | ({6'd0, a} * 32'd4);
        if (br && z) return pc4 + 32'(int'($signed(c)) * 4);
        return pc4;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_wait = 0; m_pc = RESET_PC; m_instr = 32'h0; m_err = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_PC"}, PC, RESET_PC);
        chk({tag, "_InstrReg"}, InstrReg, 32'h0);
        chk({tag, "_valid"}, instr_valid, 0);
        chk({tag, "_req"}, bus.imem_req, 0);
        chk({tag, "_err"}, fetch_err, 0);
    endtask

    // Called just after a falling edge: check outputs, drive inputs, advance model.
    task automatic step();
        logic ack;
        chk("imem_req", bus.imem_req, m_mode == 1);
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("PC", PC, m_pc);
        chk("InstrReg", InstrReg, m_instr);
        chk("instr_valid", instr_valid, m_mode == 2);
        chk("fetch_err", fetch_err, m_err);
        if (m_mode == 1) begin
            ack = (m_wait == d_lat);
            bus.imem_ack   = ack;
            bus.imem_rdata = ack ? d_data : $urandom;
        end else begin
            ack = 1'b0;
            bus.imem_ack   = 1'($urandom);
            bus.imem_rdata = $urandom;
        end
        if (m_mode == 2) begin
            Branch = d_br; Zero = d_z; Jump = d_j; br_const = d_c; address = d_a; stall = d_st;
        end else begin
            Branch = 1'($urandom); Zero = 1'($urandom); Jump = 1'($urandom);
            br_const = 16'($urandom); address = 26'($urandom); stall = 1'b0;
        end
        case (m_mode)
            0: begin m_mode = 1; m_wait = 0; end
            1: if (ack) begin
                   m_instr = d_data; m_mode = 2;
               end else begin
                   m_wait++;
                   if (TO_EN && m_wait == TO) begin m_mode = 3; m_err = 1'b1; end
               end
            2: if (!d_st) begin
                   m_pc = ref_next(m_pc, d_br, d_z, d_j, d_c, d_a);
                   m_mode = 1; m_wait = 0;
               end
            default: ;
        endcase
        @(negedge clk);
    endtask

    task automatic wait_exec();
        int guard = 0;
        while (m_mode != 2 && guard < 40) begin step(); guard++; end
        if (m_mode != 2) chk("exec_guard", guard, 0);
    endtask

    task automatic run_instr(input logic br, z, j, input logic [15:0] c, input logic [25:0] a,
                             input int nstall, input int lat, input logic [31:0] data);
        d_br = br; d_z = z; d_j = j; d_c = c; d_a = a; d_lat = lat; d_data = data;
        d_st = 1'b0;
        wait_exec();
        d_st = 1'b1;
        for (int i = 0; i < nstall; i++) step();
        d_st = 1'b0;
        step();
    endtask

    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 chk_reset({tag, "_async"});
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        #1 chk_reset({tag, "_held"});
        @(negedge clk);
        bus.imem_ack = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n = 1'b0;
        Branch = 0; Zero = 0; Jump = 0; stall = 0; br_const = 0; address = 0;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
        d_st = 0; d_lat = 0; d_data = 0;
        #1 chk_reset("por");
        repeat (2) @(posedge clk);
        #1 chk_reset("por_held");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // First fetch with a 2-cycle ack, then sequential to 0x4
        run_instr(0, 0, 0, 16'h0, 26'h0, 0, 2, 32'h20080005);
        chk("first_next_addr", bus.imem_addr, 32'h4);
        run_instr(0, 0, 1, 16'h0, 26'h10, 0, 1, $urandom);       // -> 0x40
        run_instr(1, 1, 0, 16'hFFFE, 26'h0, 0, 0, $urandom);     // -> 0x3C
        chk("branch_taken", bus.imem_addr, 32'h3C);
        run_instr(0, 0, 1, 16'h0, 26'h4, 0, 3, $urandom);        // -> 0x10
        run_instr(1, 1, 1, 16'h0001, 26'h100, 0, 0, $urandom);   // Jump wins -> 0x400
        chk("jump_priority", bus.imem_addr, 32'h400);
        run_instr(0, 0, 1, 16'h0, 26'h10, 0, 1, $urandom);       // -> 0x40
        run_instr(1, 0, 0, 16'hFFFE, 26'h0, 0, 2, $urandom);     // not taken -> 0x44
        chk("branch_not_taken", bus.imem_addr, 32'h44);
        run_instr(0, 0, 1, 16'h0, 26'h0, 0, 0, $urandom);        // -> 0x0
        run_instr(0, 0, 0, 16'h0, 26'h0, 3, 1, 32'hA5A5_0001);   // stalled 3 cycles -> 0x4
        chk("stall_advance", bus.imem_addr, 32'h4);
        run_instr(0, 0, 1, 16'h0, 26'h0, 0, 0, $urandom);        // -> 0x0
        run_instr(1, 1, 0, 16'hFFFE, 26'h0, 0, 0, $urandom);     // -> 0xFFFFFFFC
        chk("neg_wrap", bus.imem_addr, 32'hFFFF_FFFC);
        run_instr(0, 0, 0, 16'h0, 26'h0, 0, 1, $urandom);        // wraps -> 0x0
        chk("pc_wrap", bus.imem_addr, 32'h0);

        for (int n = 0; n < 60; n++)
            run_instr(1'($urandom), 1'($urandom), ($urandom % 4) == 0, 16'($urandom),
                      26'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), $urandom);

        // Reset mid-FETCH with a late ack
        d_lat = 1000;
        repeat (2) step();
        do_reset("rst_fetch");

        // Reset mid-EXEC
        d_lat = 0; d_data = 32'h1234_5678; d_st = 1'b1;
        d_br = 0; d_z = 0; d_j = 0; d_c = 0; d_a = 0;
        wait_exec();
        step();
        do_reset("rst_exec");

        // No ack at all: timeout to ERROR, or wait forever without the feature
        d_lat = 1000;
        repeat (TO + 6) step();
        chk("timeout_err", fetch_err, TO_EN);
        chk("timeout_req", bus.imem_req, !TO_EN);
        do_reset("rst_error");
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
